// File: rtl/program_memory_pkg.sv
// Shared definitions for the program-memory responder.
//   - default geometry of the instruction store
//   - width of the response latency counter
//   - responder FSM state type
package program_memory_pkg;

    localparam int PM_ADDR_BITS = 8;
    localparam int PM_DATA_BITS = 16;
    localparam int PM_DEPTH     = 256;

    // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 15.
    localparam int LAT_CNT_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_RESPOND  = 2'd2,
        ST_COOLDOWN = 2'd3
    } pm_state_e;

endpackage

// File: rtl/program_memory_array.sv
// Instruction store: one synchronous read port and one write port.
// Ports:
//   clk, reset           clock, asynchronous active-low reset (read register only)
//   rd_en, rd_addr       read strobe/address; rd_data updates on the strobed edge
//   rd_data              registered read word, held between reads
//   wr_en, wr_addr,      write strobe/address/data
//   wr_data
// Reads of the word being written in the same cycle return the old contents.
// Out-of-range reads return zero; out-of-range writes are dropped.
module program_memory_array
    import program_memory_pkg::*;
#(
    parameter int ADDR_BITS = PM_ADDR_BITS,
    parameter int DATA_BITS = PM_DATA_BITS,
    parameter int DEPTH     = PM_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data
);

    localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS:0] DEPTH_LIM = (ADDR_BITS + 1)'(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic                 rd_in_range;
    logic                 wr_in_range;

    // Extra top bit lets DEPTH == 2**ADDR_BITS compare without overflow.
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);

    // Storage is never reset so a loaded image survives a responder reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[IDX_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_in_range ? mem[rd_addr[IDX_BITS-1:0]] : '0;
        end
    end

endmodule

// File: rtl/program_memory_responder.sv
// Responder end of the program-memory read channel.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   mem_read_valid/_address    request from the program controller
//   mem_read_ready             one-cycle pulse, mem_read_data valid this cycle
//   mem_read_data              returned word, held until the next response
//   load_valid/_address/_data  host image load, one word per cycle
//   busy                       request accepted and not yet past cooldown
//   read_count                 completed responses, wraps at 2**16
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | waiting for mem_read_valid; accepts and latches address
// ST_WAIT     | counting down latency; array read fires at count zero
// ST_RESPOND  | mem_read_ready high for this single cycle
// ST_COOLDOWN | controller's stale valid ignored; busy drops on exit
module program_memory_responder
    import program_memory_pkg::*;
#(
    parameter int ADDR_BITS    = PM_ADDR_BITS,
    parameter int DATA_BITS    = PM_DATA_BITS,
    parameter int DEPTH        = PM_DEPTH,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_read_valid,
    input  logic [ADDR_BITS-1:0] mem_read_address,
    output logic                 mem_read_ready,
    output logic [DATA_BITS-1:0] mem_read_data,
    input  logic                 load_valid,
    input  logic [ADDR_BITS-1:0] load_address,
    input  logic [DATA_BITS-1:0] load_data,
    output logic                 busy,
    output logic [15:0]          read_count
);

    localparam logic [LAT_CNT_BITS-1:0] LAT_LOAD = LAT_CNT_BITS'(READ_LATENCY - 1);

    pm_state_e               state;
    pm_state_e               state_nxt;
    logic [LAT_CNT_BITS-1:0] lat_cnt;
    logic [LAT_CNT_BITS-1:0] lat_cnt_nxt;
    logic [ADDR_BITS-1:0]    req_addr;
    logic [ADDR_BITS-1:0]    req_addr_nxt;
    logic                    ready_nxt;
    logic                    busy_nxt;
    logic [15:0]             count_nxt;
    logic                    rd_fire;

    program_memory_array #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_fire),
        .rd_addr (req_addr),
        .rd_data (mem_read_data),
        .wr_en   (load_valid),
        .wr_addr (load_address),
        .wr_data (load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            lat_cnt        <= '0;
            req_addr       <= '0;
            mem_read_ready <= 1'b0;
            busy           <= 1'b0;
            read_count     <= '0;
        end else begin
            state          <= state_nxt;
            lat_cnt        <= lat_cnt_nxt;
            req_addr       <= req_addr_nxt;
            mem_read_ready <= ready_nxt;
            busy           <= busy_nxt;
            read_count     <= count_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lat_cnt_nxt  = lat_cnt;
        req_addr_nxt = req_addr;
        ready_nxt    = 1'b0;
        busy_nxt     = busy;
        count_nxt    = read_count;
        rd_fire      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (mem_read_valid) begin
                    req_addr_nxt = mem_read_address;
                    lat_cnt_nxt  = LAT_LOAD;
                    busy_nxt     = 1'b1;
                    state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Valid is not watched here: a dropped request still completes.
                if (lat_cnt != '0) begin
                    lat_cnt_nxt = lat_cnt - 1'b1;
                end else begin
                    rd_fire   = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                count_nxt = read_count + 16'd1;
                state_nxt = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_program_memory_responder.sv
// Directed bench for program_memory_responder: three instances share clock,
// reset and the load port.
//   dut   : default geometry, latency 2
//   dut_b : 128-word store, latency 2
//   dut_c : default geometry, latency 1
module tb_program_memory_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;

    logic        v_a, v_b, v_c;
    logic [7:0]  a_a, a_b, a_c;
    logic        rdy_a, rdy_b, rdy_c;
    logic [15:0] dat_a, dat_b, dat_c;
    logic        bsy_a, bsy_b, bsy_c;
    logic [15:0] cnt_a, cnt_b, cnt_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rdy = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    program_memory_responder #(.READ_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .mem_read_valid(v_a), .mem_read_address(a_a),
        .mem_read_ready(rdy_a), .mem_read_data(dat_a),
        .load_valid(ld_valid), .load_address(ld_addr), .load_data(ld_data),
        .busy(bsy_a), .read_count(cnt_a)
    );

    program_memory_responder #(.DEPTH(128), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset),
        .mem_read_valid(v_b), .mem_read_address(a_b),
        .mem_read_ready(rdy_b), .mem_read_data(dat_b),
        .load_valid(ld_valid), .load_address(ld_addr), .load_data(ld_data),
        .busy(bsy_b), .read_count(cnt_b)
    );

    program_memory_responder #(.READ_LATENCY(1)) dut_c (
        .clk(clk), .reset(reset),
        .mem_read_valid(v_c), .mem_read_address(a_c),
        .mem_read_ready(rdy_c), .mem_read_data(dat_c),
        .load_valid(ld_valid), .load_address(ld_addr), .load_data(ld_data),
        .busy(bsy_c), .read_count(cnt_c)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // sel: 0 ready, 1 data, 2 busy, 3 read_count
    function automatic logic [31:0] obs(input int w, input int sel);
        logic        r, b;
        logic [15:0] d, c;
        case (w)
            0:       begin r = rdy_a; d = dat_a; b = bsy_a; c = cnt_a; end
            1:       begin r = rdy_b; d = dat_b; b = bsy_b; c = cnt_b; end
            default: begin r = rdy_c; d = dat_c; b = bsy_c; c = cnt_c; end
        endcase
        case (sel)
            0:       return {31'd0, r};
            1:       return {16'd0, d};
            2:       return {31'd0, b};
            default: return {16'd0, c};
        endcase
    endfunction

    task automatic set_req(input int w, input logic v, input logic [7:0] a);
        case (w)
            0:       begin v_a = v; a_a = a; end
            1:       begin v_b = v; a_b = a; end
            default: begin v_c = v; a_c = a; end
        endcase
    endtask

    task automatic load_word(input logic [7:0] a, input logic [15:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_valid = 1'b0;
    endtask

    // One controller-style transaction. Step k means "just after edge E_k",
    // E_0 being the accepting edge. Valid stays high through E_(lat+1), the
    // edge that sees ready; (nv, na) is what the controller drives during
    // the cooldown cycle. ld_at selects the edge that also takes a host load.
    task automatic read_txn(input int w, input int lat, input logic [7:0] addr,
                            input logic [15:0] exp_data, input logic [15:0] exp_cnt,
                            input int ld_at, input logic [7:0] ld_a, input logic [15:0] ld_d,
                            input bit drop, input bit nv, input logic [7:0] na,
                            input bit gap, input string tag);
        for (int k = 0; k <= lat + 2; k++) begin
            if (k == 0) set_req(w, 1'b1, addr);
            else if (k == lat + 2) set_req(w, nv, na);
            else if (drop) set_req(w, 1'b0, addr);
            ld_valid = (k == ld_at);
            ld_addr  = ld_a;
            ld_data  = ld_d;
            @(posedge clk); #1;
            check({tag, " ready"}, obs(w, 0), {31'd0, k == lat});
            check({tag, " busy"}, obs(w, 2), {31'd0, k <= lat + 1});
            if (k == lat) begin
                check({tag, " data"}, obs(w, 1), {16'd0, exp_data});
                if (gap) check({tag, " gap"}, cyc - last_rdy, lat + 3);
                last_rdy = cyc;
            end
            if (k == lat + 1) check({tag, " count"}, obs(w, 3), {16'd0, exp_cnt});
        end
        ld_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        v_a = 1'b0; v_b = 1'b0; v_c = 1'b0;
        a_a = '0; a_b = '0; a_c = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", obs(0, 0), 0);
        check("rst data", obs(0, 1), 0);
        check("rst busy", obs(0, 2), 0);
        check("rst count", obs(0, 3), 0);
        check("rst count_c", obs(2, 3), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        load_word(8'h00, 16'h1111);
        load_word(8'h01, 16'h2222);
        load_word(8'h02, 16'h3333);
        load_word(8'h03, 16'h4444);
        load_word(8'hFF, 16'hBEEF);
        load_word(8'h80, 16'h5A5A);
        load_word(8'h7F, 16'h7777);

        // basic read, then valid reasserted at once for the next address
        read_txn(0, 2, 8'h02, 16'h3333, 16'd1, -1, 8'h00, 16'h0, 1'b0, 1'b1, 8'h01, 1'b0, "r_a2");
        read_txn(0, 2, 8'h01, 16'h2222, 16'd2, -1, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 1'b1, "r_a1");
        read_txn(0, 2, 8'hFF, 16'hBEEF, 16'd3, -1, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, "r_aFF");
        read_txn(0, 2, 8'h80, 16'h5A5A, 16'd4, -1, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, "r_a80");

        // 128-word store: top in-range word, then out-of-range reads
        read_txn(1, 2, 8'h7F, 16'h7777, 16'd1, -1, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, "b_7F");
        read_txn(1, 2, 8'h80, 16'h0000, 16'd2, -1, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, "b_80");
        read_txn(1, 2, 8'hFF, 16'h0000, 16'd3, -1, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, "b_FF");

        // load on the array-read edge returns the old word; next read the new one
        read_txn(0, 2, 8'h03, 16'h4444, 16'd5, 2, 8'h03, 16'hABCD, 1'b0, 1'b0, 8'h00, 1'b0, "rbw_old");
        read_txn(0, 2, 8'h03, 16'hABCD, 16'd6, -1, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, "rbw_new");
        // load during the countdown, before the read edge, is visible
        read_txn(0, 2, 8'h00, 16'h0F0F, 16'd7, 1, 8'h00, 16'h0F0F, 1'b0, 1'b0, 8'h00, 1'b0, "wait_ld");
        // valid dropped mid-wait: response still completes
        read_txn(0, 2, 8'h02, 16'h3333, 16'd8, -1, 8'h00, 16'h0, 1'b1, 1'b0, 8'h00, 1'b0, "drop");

        // reset during the countdown abandons the transaction
        set_req(0, 1'b1, 8'h01);
        @(posedge clk); #1;
        check("mid accept busy", obs(0, 2), 1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("mid rst ready", obs(0, 0), 0);
        check("mid rst busy", obs(0, 2), 0);
        check("mid rst count", obs(0, 3), 0);
        check("mid rst data", obs(0, 1), 0);
        set_req(0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("in rst ready", obs(0, 0), 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post rst ready", obs(0, 0), 0);
        check("post rst count", obs(0, 3), 0);
        read_txn(0, 2, 8'h01, 16'h2222, 16'd1, -1, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 1'b0, "post_rst");

        // latency-1 instance: counter preset near the top, then reads across the wrap
        force dut_c.read_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut_c.read_count;
        @(posedge clk); #1;
        check("wrap preset", obs(2, 3), 32'h0000FFFE);
        for (int i = 0; i < 4; i++) begin
            logic [7:0]  ad;
            logic [15:0] ed, ec;
            ad = (i % 2 == 1) ? 8'h02 : 8'h01;
            ed = (i % 2 == 1) ? 16'h3333 : 16'h2222;
            ec = 16'hFFFF + 16'(i);
            read_txn(2, 1, ad, ed, ec, -1, 8'h00, 16'h0, 1'b0, (i < 3), (i % 2 == 1) ? 8'h01 : 8'h02,
                     (i > 0), "wrap");
        end
        check("wrap final", obs(2, 3), 32'h00000002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
